mips_cpu_pc_seq: RTL
====================

// Module: mips_cpu_pc_seq
// PURPOSE
//  Parametrised program-counter sequencer for the MIPS CPU. Holds the fetch PC and
//  resolves sequential/branch/jump/jump-register redirects, with an optional
//  architectural branch delay slot. Also handles a stall input, exception
//  redirection and halt-on-address detection. Sits between decode/regfile and fetch.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  pc_out value after reset
//  HALT_ADDR     32'h00000000  reaching this PC deasserts active and freezes sequencer
//  EXC_VECTOR    32'hBFC00180  redirect target when exc is taken
//  DELAY_SLOT    1             1: redirect after one delay-slot instr; 0: immediate
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, asynchronous, active-low (rst==0 resets)
//  stall         in   1   1: hold all state this cycle (advance = ~stall & active)
//  pc_ctrl       in   2   0 seq, 1 branch, 2 jump (J/JAL), 3 jump-register
//  branch_taken  in   1   branch condition; only used when pc_ctrl==1
//  instr         in   32  instruction currently at pc_out (imm16 / index26)
//  reg_readdata  in   32  rs value for pc_ctrl==3
//  exc           in   1   exception request for instruction at pc_out
//  pc_out        out  32  current fetch PC
//  pc_link       out  32  pc_out+8 (link address for JAL/JALR/BxxAL)
//  active        out  1   1 while running; 0 once HALT_ADDR reached
//  in_delay_slot out  1   1 when pc_out is a delay-slot instruction (state DELAY)
//  addr_err      out  1   sticky: a redirect target had [1:0]!=0
// BEHAVIOUR
//  Reset (async, rst==0): pc_out=RESET_VECTOR, state=RUN, target_q=0,
//   active=1, in_delay_slot=0, addr_err=0. Release is synchronous to clk.
//  States: RUN, DELAY (redirect pending, pc_out is delay slot), HALTED.
//  Target (32-bit, wraps mod 2^32; pc4 = pc_out+4):
//   ctrl1 taken: pc4 + {{14{instr[15]}},instr[15:0],2'b00}
//   ctrl2: {pc4[31:28], instr[25:0], 2'b00}; ctrl3: reg_readdata
//   redirect = (ctrl==1 & branch_taken) | ctrl==2 | ctrl==3
//  Priority on an advance edge: exc > DELAY completion > new redirect > sequential.
//   exc: pc_out<=EXC_VECTOR, state<=RUN, pending target discarded.
//   state DELAY: pc_out<=target_q, state<=RUN; pc_ctrl ignored
//    (branch in delay slot is not supported, no error raised).
//   RUN & redirect, DELAY_SLOT=1: target_q<=target, pc_out<=pc4, state<=DELAY.
//   RUN & redirect, DELAY_SLOT=0: pc_out<=target, state stays RUN.
//   otherwise: pc_out<=pc4.
//  addr_err set on the edge a redirect target with [1:0]!=0 is latched/applied;
//   target is used unmodified; cleared only by reset.
//  stall==1: pc_out, state, target_q and addr_err hold; exc/pc_ctrl not sampled.
//  Halt: on any edge with active==1 and pc_out==HALT_ADDR (stall irrelevant),
//   active<=0, state<=HALTED. HALTED: all state frozen until reset.
//   JR to 0 with DELAY_SLOT=1: delay slot runs, pc_out=0, active drops next edge.
//  Outputs are pure functions of registered state: pc_link=pc_out+8,
//   in_delay_slot=(state==DELAY); no combinational input->output paths.
//  Reset asserted mid-DELAY discards target_q; next fetch is RESET_VECTOR.
// TESTING
//  1 reset, 3 seq edges -> pc_out BFC00000,04,08,0C; pc_link=BFC00014; active=1.
//  2 pc=BFC00010, ctrl=1, taken, imm=FFFE -> BFC00014 (in_delay_slot=1), then
//    BFC0000C; not taken -> BFC00014, BFC00018.
//  3 DELAY_SLOT=0, pc=BFC00000, ctrl=2, idx=0x0100040 -> next pc_out=B0400100.
//  4 ctrl=3, rd=0 at BFC00008 -> BFC0000C, 00000000, then active=0, pc frozen 5 cyc.
//  5 stall=1 for 3 cycles in DELAY -> pc_out/in_delay_slot held; exc in DELAY
//    -> pc_out=BFC00180, target discarded; ctrl=3 rd=BFC00002 -> addr_err=1.
//  6 rst=0 pulsed mid-cycle in DELAY -> immediate BFC00000, active=1, flags 0.

Source files
------------

// File: rtl/mips_cpu_pc_seq.sv
// mips_cpu_pc_seq
//   Program-counter sequencer for the MIPS CPU. Holds the fetch PC and steps it
//   sequentially or redirects it for branches, jumps and jump-register. When
//   DELAY_SLOT is set, the redirect takes effect after one delay-slot
//   instruction. The block also handles stalls, exception redirection and
//   halting on a fixed address.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   stall         in   hold all state this cycle
//   pc_ctrl       in   0 seq, 1 branch, 2 jump, 3 jump-register
//   branch_taken  in   branch condition (pc_ctrl==1 only)
//   instr         in   instruction at pc_out (imm16 / index26 source)
//   reg_readdata  in   rs value for jump-register
//   exc           in   exception request for instruction at pc_out
//   pc_out        out  current fetch PC
//   pc_link       out  pc_out+8 link address
//   active        out  1 while running, 0 once HALT_ADDR is reached
//   in_delay_slot out  pc_out is a delay-slot instruction
//   addr_err      out  sticky: some redirect target was misaligned
module mips_cpu_pc_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00180,
    parameter int          DELAY_SLOT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pc_ctrl,
    input  logic        branch_taken,
    input  logic [31:0] instr,
    input  logic [31:0] reg_readdata,
    input  logic        exc,
    output logic [31:0] pc_out,
    output logic [31:0] pc_link,
    output logic        active,
    output logic        in_delay_slot,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DELAY  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        active_q, active_d;
    logic        aerr_q, aerr_d;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] target;
    logic        redirect;
    logic        advance;
    logic        halt_hit;

    // Opcode bits never affect the PC.
    logic        unused_opcode;
    assign unused_opcode = ^instr[31:26];

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        target = pc4;
        unique case (pc_ctrl)
            2'd1:    target = pc4 + br_off;
            2'd2:    target = {pc4[31:28], instr[25:0], 2'b00};
            2'd3:    target = reg_readdata;
            default: target = pc4;
        endcase
    end

    assign redirect = ((pc_ctrl == 2'd1) && branch_taken) ||
                      (pc_ctrl == 2'd2) || (pc_ctrl == 2'd3);
    assign advance  = !stall && active_q;
    // Halt detection ignores stall so a stalled pipeline still stops here.
    assign halt_hit = active_q && (pc_q == HALT_ADDR);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        active_d = active_q;
        aerr_d   = aerr_q;
        if (halt_hit) begin
            active_d = 1'b0;
            state_d  = S_HALTED;
        end else if (advance) begin
            if (exc) begin
                // Exception wins over everything; any pending redirect is dropped.
                pc_d    = EXC_VECTOR;
                state_d = S_RUN;
                tgt_d   = '0;
            end else if (state_q == S_DELAY) begin
                // Control flow in a delay slot is not supported and ignored.
                pc_d    = tgt_q;
                state_d = S_RUN;
            end else if (redirect) begin
                if (target[1:0] != 2'b00) aerr_d = 1'b1;
                if (DELAY_SLOT != 0) begin
                    tgt_d   = target;
                    pc_d    = pc4;
                    state_d = S_DELAY;
                end else begin
                    pc_d = target;
                end
            end else begin
                pc_d = pc4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_VECTOR;
            tgt_q    <= '0;
            active_q <= 1'b1;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            active_q <= active_d;
            aerr_q   <= aerr_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_link       = pc_q + 32'd8;
    assign active        = active_q;
    assign in_delay_slot = (state_q == S_DELAY);
    assign addr_err      = aerr_q;

endmodule
